data_memory_manager_v2: RTL and testbench

Parametrised, word-addressed data memory for the processor datapath. It replaces the single-width, always-ready DataMemoryManager. It adds:
- a request/ready handshake;
- byte-lane write enables;
- a fixed two-cycle registered read with a valid strobe;
- out-of-range detection.

It sits between the core's load/store unit and on-chip block RAM.

---
 rtl/data_memory_manager_v2.sv | 175 +++++++++++++++++
 tb/tb_data_memory_manager_v2.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_manager_v2.sv
// Word-addressed data memory with req/ready handshake, byte lanes, 2-cycle reads.
// Optional access counters at DEPTH/DEPTH+1 when DMM_ACCESS_CNT_EN is defined.
module data_memory_manager_v2 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_i,
  input  logic                wren_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic                ready_o,
  output logic                valid_o,
  output logic [DATA_W-1:0]   data_o,
  output logic                err_o
);

  localparam int NB = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_ram_q;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_rd_word;
  logic              r_rd_err;
  logic              r_err;
  logic              w_ready;
  logic              w_valid;
  logic              w_acc;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_oor;
  logic              w_bad;
  logic [IDX_W-1:0]  w_idx;

  assign ready_o  = w_ready && !RST;
  assign valid_o  = w_valid && !RST;
  assign data_o   = r_data;
  assign err_o    = r_err;
  assign w_acc    = req_i && ready_o;
  assign w_rd_acc = w_acc && !wren_i;
  assign w_wr_acc = w_acc && wren_i;
  assign w_oor    = address_i >= LP_DEPTH;
  assign w_idx    = address_i[IDX_W-1:0];

`ifdef DMM_ACCESS_CNT_EN
  localparam logic [ADDR_W-1:0] LP_WCNT = ADDR_W'(DEPTH + 1);

  logic        w_is_rc;
  logic        w_is_wc;
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  assign w_is_rc = address_i == LP_DEPTH;
  assign w_is_wc = address_i == LP_WCNT;
  assign w_bad   = w_oor && !w_is_rc && !w_is_wc;

  // saturating access counters; a write to a counter address clears it
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_wr_acc && w_is_rc)
        r_rd_cnt <= '0;
      else if (w_rd_acc && !w_oor && r_rd_cnt != '1)
        r_rd_cnt <= r_rd_cnt + 32'd1;
      if (w_wr_acc && w_is_wc)
        r_wr_cnt <= '0;
      else if (w_wr_acc && !w_oor && r_wr_cnt != '1)
        r_wr_cnt <= r_wr_cnt + 32'd1;
    end
  end

  // read source: RAM word, counter, or zero when out of range
  always_comb begin
    w_rd_word = '0;
    if (!w_oor)
      w_rd_word = r_mem[w_idx];
    else if (w_is_rc)
      w_rd_word = DATA_W'(r_rd_cnt);
    else if (w_is_wc)
      w_rd_word = DATA_W'(r_wr_cnt);
  end
`else
  assign w_bad = w_oor;

  // read source: RAM word, or zero when out of range
  always_comb begin
    w_rd_word = '0;
    if (!w_oor)
      w_rd_word = r_mem[w_idx];
  end
`endif

  // byte-lane writes; memory is never reset
  always_ff @(posedge CLK) begin
    if (w_wr_acc && !w_oor) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k])
          r_mem[w_idx][8*k +: 8] <= data_i[8*k +: 8];
      end
    end
  end

  // RAM output register, captured at read acceptance
  always_ff @(posedge CLK) begin
    if (w_rd_acc)
      r_ram_q <= w_rd_word;
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (req_i && !wren_i)
          w_next = RD_WAIT;
      end
      RD_WAIT: begin
        w_next = RD_DONE;
      end
      RD_DONE: begin
        w_ready = 1'b1;
        w_valid = 1'b1;
        if (req_i && !wren_i)
          w_next = RD_WAIT;
        else
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // read data, read error tracking and error pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_data   <= '0;
      r_err    <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_err <= (w_wr_acc && w_bad) ||
               (r_state == RD_WAIT && r_rd_err);
      if (w_rd_acc)
        r_rd_err <= w_bad;
      if (r_state == RD_WAIT)
        r_data <= r_ram_q;
    end
  end

endmodule

// File: tb/tb_data_memory_manager_v2.sv
// Directed bench for data_memory_manager_v2.
// Counter checks run when DMM_ACCESS_CNT_EN is defined.
module tb_data_memory_manager_v2;

  localparam int DEPTH = 1024;

  logic        CLK;
  logic        RST;
  logic        req_i;
  logic        wren_i;
  logic [3:0]  be_i;
  logic [31:0] address_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        err_o;

  int n_tot;
  int n_bad;

  data_memory_manager_v2 #(
    .DATA_W(32),
    .ADDR_W(32),
    .DEPTH (DEPTH)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req_i    (req_i),
    .wren_i   (wren_i),
    .be_i     (be_i),
    .address_i(address_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .err_o    (err_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] be);
    req_i     = 1'b1;
    wren_i    = 1'b1;
    address_i = a;
    data_i    = d;
    be_i      = be;
    step();
    req_i  = 1'b0;
    wren_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [31:0] exp,
                    input logic experr,
                    input string tag);
    req_i     = 1'b1;
    wren_i    = 1'b0;
    address_i = a;
    #1;
    chk({tag, "_rdy"}, {31'd0, ready_o}, 32'd1);
    step();
    req_i = 1'b0;
    chk({tag, "_v1"}, {31'd0, valid_o}, 32'd0);
    step();
    chk({tag, "_v2"}, {31'd0, valid_o}, 32'd1);
    chk({tag, "_dat"}, data_o, exp);
    chk({tag, "_err"}, {31'd0, err_o}, {31'd0, experr});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tot     = 0;
    n_bad     = 0;
    RST       = 1'b1;
    req_i     = 1'b0;
    wren_i    = 1'b0;
    be_i      = 4'h0;
    address_i = '0;
    data_i    = '0;

    // reset state
    step();
    step();
    chk("rst_rdy", {31'd0, ready_o}, 32'd0);
    chk("rst_val", {31'd0, valid_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_dat", data_o, 32'd0);
    RST = 1'b0;
    #1;
    chk("rel_rdy", {31'd0, ready_o}, 32'd1);

    // 1: fill and readback
    for (int i = 0; i < 1000; i++) begin
      wr(i, i, 4'hF);
      chk("fill_err", {31'd0, err_o}, 32'd0);
    end
    for (int i = 0; i < 1000; i++)
      rd(i, i, 1'b0, "fill");

    // 2: byte lanes
    wr(5, 32'h1122_3344, 4'hF);
    wr(5, 32'hAABB_CCDD, 4'b0101);
    wr(6, 32'hDEAD_BEEF, 4'h0);
    rd(5, 32'h11BB_33DD, 1'b0, "lane");
    rd(6, 32'd6, 1'b0, "be0");

    // 3: back-to-back reads
    wr(7, 32'hA5, 4'hF);
    wr(9, 32'h5A, 4'hF);
    req_i     = 1'b1;
    wren_i    = 1'b0;
    address_i = 7;
    #1;
    chk("b2b_r0", {31'd0, ready_o}, 32'd1);
    step();
    address_i = 9;
    #1;
    chk("b2b_r1", {31'd0, ready_o}, 32'd0);
    chk("b2b_v1", {31'd0, valid_o}, 32'd0);
    step();
    chk("b2b_r2", {31'd0, ready_o}, 32'd1);
    chk("b2b_v2", {31'd0, valid_o}, 32'd1);
    chk("b2b_d2", data_o, 32'hA5);
    step();
    req_i = 1'b0;
    #1;
    chk("b2b_r3", {31'd0, ready_o}, 32'd0);
    chk("b2b_v3", {31'd0, valid_o}, 32'd0);
    chk("b2b_hold", data_o, 32'hA5);
    step();
    chk("b2b_v4", {31'd0, valid_o}, 32'd1);
    chk("b2b_d4", data_o, 32'h5A);
    step();
    chk("b2b_v5", {31'd0, valid_o}, 32'd0);
    chk("b2b_hold2", data_o, 32'h5A);

    // 4: out of range
    wr(DEPTH + 5, 32'hFFFF_FFFF, 4'hF);
    chk("oor_werr", {31'd0, err_o}, 32'd1);
    step();
    chk("oor_werr0", {31'd0, err_o}, 32'd0);
    rd(DEPTH + 5, 32'd0, 1'b1, "oor_rd");
    step();
    chk("oor_rerr0", {31'd0, err_o}, 32'd0);
    rd(5, 32'h11BB_33DD, 1'b0, "noalias");

    // 5: reset during RD_WAIT
    req_i     = 1'b1;
    wren_i    = 1'b0;
    address_i = 3;
    step();
    req_i = 1'b0;
    RST   = 1'b1;
    #1;
    chk("mid_rdy_rst", {31'd0, ready_o}, 32'd0);
    step();
    chk("mid_val", {31'd0, valid_o}, 32'd0);
    chk("mid_dat", data_o, 32'd0);
    chk("mid_rdy_hi", {31'd0, ready_o}, 32'd0);
    RST = 1'b0;
    #1;
    chk("mid_rdy_rel", {31'd0, ready_o}, 32'd1);
    step();
    chk("mid_val2", {31'd0, valid_o}, 32'd0);
    step();
    chk("mid_val3", {31'd0, valid_o}, 32'd0);
    chk("mid_dat3", data_o, 32'd0);
    rd(3, 32'd3, 1'b0, "after_rst");

`ifdef DMM_ACCESS_CNT_EN
    // 6: access counters
    RST = 1'b1;
    step();
    RST = 1'b0;
    wr(10, 32'h100, 4'hF);
    wr(11, 32'h101, 4'hF);
    wr(12, 32'h102, 4'h0);
    rd(10, 32'h100, 1'b0, "cnt_r10");
    rd(11, 32'h101, 1'b0, "cnt_r11");
    rd(DEPTH, 32'd2, 1'b0, "rdcnt");
    rd(DEPTH + 1, 32'd3, 1'b0, "wrcnt");
    wr(DEPTH, 32'hFFFF, 4'h0);
    chk("clr_err", {31'd0, err_o}, 32'd0);
    rd(DEPTH, 32'd0, 1'b0, "rdcnt_clr");
    rd(DEPTH + 1, 32'd3, 1'b0, "wrcnt_keep");
`else
    // counter addresses are plain out-of-range slots
    rd(DEPTH, 32'd0, 1'b1, "nocnt0");
    rd(DEPTH + 1, 32'd0, 1'b1, "nocnt1");
`endif

    step();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
